// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB LED output stage.
// Colour codes are {red, green, blue}, matching the comparator flag order.
package rgb_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    LOCK  = 2'd1,
    READY = 2'd2
  } drv_state_t;

  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_BLUE  = 3'b001;
  localparam logic [2:0] COL_NONE  = 3'b000;

  // True only for the three legal colour codes; 000 and multi-bit codes are rejected.
  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == COL_RED) || (v == COL_GREEN) || (v == COL_BLUE);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for one asynchronous level input.
// The first flop may go metastable; the second gives it a full cycle to settle.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the raw input through two flops; synchronous reset clears both.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make both flops sample their old values on the
    // same edge; blocking ones here would collapse the chain into a single flop.
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/rgb_led_driver.sv
// RGB LED driver behind the 2-bit comparator.
// Synchronises the three colour flags, accepts only one-hot codes, holds each newly
// shown colour for HOLD_CYCLES before another change, and PWM-dims the LED outputs.
module rgb_led_driver
  import rgb_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red_in,
  input  logic             green_in,
  input  logic             blue_in,
  input  logic [CNT_W-1:0] duty,
  output logic             led_r,
  output logic             led_g,
  output logic             led_b,
  output logic             code_err
);

  localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  PWM_LAST  = '1;

  // Synchronised comparator flags
  logic       w_red_s;
  logic       w_green_s;
  logic       w_blue_s;
  logic [2:0] w_cand;
  logic       w_cand_ok;

  // Colour selection FSM
  drv_state_t        r_state;
  drv_state_t        w_state_nxt;
  logic [2:0]        r_cur_col;
  logic [2:0]        w_cur_col_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_cnt_nxt;

  // PWM
  logic [CNT_W-1:0] r_pwm_cnt;
  logic [CNT_W-1:0] r_duty_q;
  logic             r_duty_prime;
  logic             w_pwm_on;

  // Registered outputs
  logic [2:0] r_led;
  logic       r_code_err;

  sync2 u_sync_r (
    .clk (clk),
    .rst (rst),
    .i_d (red_in),
    .o_q (w_red_s)
  );

  sync2 u_sync_g (
    .clk (clk),
    .rst (rst),
    .i_d (green_in),
    .o_q (w_green_s)
  );

  sync2 u_sync_b (
    .clk (clk),
    .rst (rst),
    .i_d (blue_in),
    .o_q (w_blue_s)
  );

  assign w_cand    = {w_red_s, w_green_s, w_blue_s};
  assign w_cand_ok = is_onehot3(w_cand);

  // Next-state logic: load a new colour from OFF/READY, count out the hold in LOCK.
  always_comb begin
    // NOTE: every output of this block gets its hold value first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    w_state_nxt    = r_state;
    w_cur_col_nxt  = r_cur_col;
    w_hold_cnt_nxt = r_hold_cnt;

    case (r_state)
      OFF: begin
        if (w_cand_ok) begin
          w_cur_col_nxt  = w_cand;
          w_hold_cnt_nxt = '0;
          w_state_nxt    = LOCK;
        end
      end

      LOCK: begin
        // Candidate is deliberately ignored here; this is what suppresses bounce.
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = READY;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
      end

      READY: begin
        // hold_cnt stays at its final value here (saturated) until the next load.
        if (w_cand_ok && (w_cand != r_cur_col)) begin
          w_cur_col_nxt  = w_cand;
          w_hold_cnt_nxt = '0;
          w_state_nxt    = LOCK;
        end
      end

      default: begin
        w_state_nxt   = OFF;
        w_cur_col_nxt = COL_NONE;
      end
    endcase
  end

  // FSM state, current colour and hold counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= OFF;
      r_cur_col  <= COL_NONE;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_col  <= w_cur_col_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  // Free-running PWM counter; wraps naturally at 2**CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  // Latch duty only at a period boundary so a mid-period change never produces a
  // runt pulse. Reset starts a period at pwm_cnt=0 with no duty latched for it, so
  // the first edge out of reset also reloads; otherwise the LED would stay dark for
  // the whole first period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty_q     <= '0;
      r_duty_prime <= 1'b1;
    end else begin
      r_duty_prime <= 1'b0;
      if ((r_pwm_cnt == PWM_LAST) || r_duty_prime) begin
        r_duty_q <= duty;
      end
    end
  end

  assign w_pwm_on = (r_pwm_cnt < r_duty_q);

  // Gate the current colour with the PWM phase and flag illegal candidate codes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led      <= COL_NONE;
      r_code_err <= 1'b0;
    end else begin
      r_led      <= r_cur_col & {3{w_pwm_on}};
      r_code_err <= ~w_cand_ok;
    end
  end

  assign led_r    = r_led[2];
  assign led_g    = r_led[1];
  assign led_b    = r_led[0];
  assign code_err = r_code_err;

endmodule
